// File: rtl/clock_div_prog.sv
// Programmable clock divider with square/pulse output, period-start tick and
// glitch-free divisor updates that only take effect at a period boundary or while paused.
module clock_div_prog #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned DIV_RESET = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 mode,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div_val,
    output logic                 clk_out,
    output logic                 tick,
    output logic [DIV_WIDTH-1:0] counter,
    output logic [DIV_WIDTH-1:0] div_active,
    output logic                 upd_pending
);

    localparam int unsigned HW = DIV_WIDTH + 1;
    localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DIV_RESET);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] pend_val;

    logic [DIV_WIDTH-1:0] div_eff_c;
    logic [DIV_WIDTH-1:0] load_val_c;
    logic [DIV_WIDTH-1:0] div_nxt_c;
    logic [DIV_WIDTH-1:0] cnt_nxt_c;
    logic [DIV_WIDTH-1:0] pend_nxt_c;
    logic [HW-1:0]        high_len_c;
    logic                 wrap_c;
    logic                 xfer_c;
    logic                 clk_nxt_c;
    logic                 tick_nxt_c;
    logic                 upd_nxt_c;

    // Next-state computation: counter, divisor handover and output shape.
    always_comb begin
        div_eff_c  = (div_active == '0) ? ONE : div_active;
        load_val_c = (div_val == '0) ? ONE : div_val;
        // counter >= D-1 also catches a counter stranded above a shortened divisor
        wrap_c     = en && !clr && (counter >= (div_eff_c - ONE));
        xfer_c     = clr || !en || wrap_c;

        div_nxt_c = div_active;
        if (xfer_c) begin
            if (load) begin
                div_nxt_c = load_val_c;
            end else if (upd_pending) begin
                div_nxt_c = pend_val;
            end
        end

        cnt_nxt_c = counter;
        if (clr || wrap_c) begin
            cnt_nxt_c = '0;
        end else if (en) begin
            cnt_nxt_c = counter + ONE;
        end

        tick_nxt_c = clr || wrap_c;
        high_len_c = (HW'(div_nxt_c) + HW'(1)) >> 1;
        clk_nxt_c  = mode ? (cnt_nxt_c == '0) : (HW'(cnt_nxt_c) < high_len_c);

        pend_nxt_c = load ? load_val_c : pend_val;
        upd_nxt_c  = (load || upd_pending) && !xfer_c;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter     <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            div_active  <= RST_DIV;
            pend_val    <= RST_DIV;
            upd_pending <= 1'b0;
        end else begin
            counter     <= cnt_nxt_c;
            clk_out     <= clk_nxt_c;
            tick        <= tick_nxt_c;
            div_active  <= div_nxt_c;
            pend_val    <= pend_nxt_c;
            upd_pending <= upd_nxt_c;
        end
    end

endmodule

// File: doc/clock_div_prog.md
CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

Interface
REQ-001 Parameter DIV_WIDTH, default 8, sets the width of the divisor and counter, with a legal range of 2..16.
REQ-002 Parameter DIV_RESET, default 2, is the active divisor loaded at reset and SHALL lie in 1..2^DIV_WIDTH-1.
REQ-003 clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  is an asynchronous, active-high reset.
REQ-005 en  in  1  is the count enable.
REQ-006 clr  in  1  is a synchronous period restart.
REQ-007 mode  in  1  selects the output shape: 0 = square, 1 = pulse.
REQ-008 load  in  1  is a single-cycle strobe that captures div_val.
REQ-009 div_val  in  DIV_WIDTH  is the requested divisor.
REQ-010 clk_out  out  1  is the registered divided clock.
REQ-011 tick  out  1  is a registered one-cycle period-start strobe.
REQ-012 counter  out  DIV_WIDTH  is the phase count within the current period.
REQ-013 div_active  out  DIV_WIDTH  is the divisor currently in use.
REQ-014 upd_pending  out  1  is high while a loaded divisor is waiting to be applied.

Function
REQ-015 The effective divisor SHALL be D = max(div_active, 1); a div_val of 0 SHALL be stored as 1.
REQ-016 The high length SHALL be H = (D+1)>>1, computed at DIV_WIDTH+1 bits so that no overflow occurs.
REQ-017 Control priority SHALL be reset > clr > en.
REQ-018 On an edge with en=1 and clr=0, counter SHALL advance: 0,1,...,D-1,0,... with the wrap at D-1.
REQ-019 On an edge with en=0 and clr=0, counter and clk_out SHALL hold, and tick SHALL be 0.
REQ-020 With clr=1, counter SHALL go to 0 and tick SHALL be 1 on that edge, regardless of en.
REQ-021 After any non-reset edge, clk_out SHALL be a function of the new counter and the new div_active.
REQ-022 In square mode, clk_out SHALL be 1 iff counter < H.
REQ-023 In pulse mode, clk_out SHALL be 1 iff counter == 0.
REQ-024 tick SHALL be 1 for exactly the one cycle after a wrap edge or a clr edge, and 0 otherwise.
REQ-025 Divisor update:
- load=1 SHALL capture div_val into the pending register and set upd_pending.
- A pending value SHALL transfer to div_active on the next wrap edge, on a clr edge, or on any edge with en=0; upd_pending SHALL then clear.
- Period length SHALL never change mid-period while en=1.
REQ-026 If load coincides with a transfer edge, the newly captured div_val SHALL win and SHALL take effect on that same edge.
REQ-027 If counter >= D after a transfer (a shorter divisor applied while en=0), the next enabled edge SHALL wrap to 0.
REQ-028 A mode change SHALL take effect on the next edge, and counter SHALL be unaffected.
REQ-029 With D=1, counter SHALL stay at 0, clk_out SHALL be 1 in both modes, and tick SHALL be 1 on every enabled cycle.

Reset
REQ-030 While reset=1, all outputs SHALL be forced immediately, independent of clk:
- counter=0, clk_out=0, tick=0
- div_active=DIV_RESET, upd_pending=0, pending register=DIV_RESET
REQ-031 Reset asserted mid-period SHALL abandon the period and discard any pending divisor.
REQ-032 The first period after reset release SHALL differ from steady state: clk_out is 0 while counter=0, and the first tick follows the first wrap.

Verification
REQ-033 Square mode, odd divisor (DIV_WIDTH=4, load div_val=5, en=1 steady):
- counter SHALL cycle 0-4.
- clk_out SHALL be high for 3 cycles and low for 2.
- tick SHALL occur every 5 cycles, coincident with counter=0.
REQ-034 Pulse mode, D=4: clk_out SHALL be a 1-cycle-high, 3-cycle-low pattern, and tick SHALL be identical to clk_out after the first wrap.
REQ-035 Mid-period divisor change (D=6, load div_val=3 at counter=2):
- upd_pending SHALL be 1 until the wrap.
- The current period SHALL complete at 6 cycles.
- The following periods SHALL be 3 cycles.
REQ-036 Enable pause (D=8, en=0 at counter=5 for 4 cycles, then en=1):
- counter and clk_out SHALL hold at 5 and 0, and tick SHALL stay 0.
- Counting SHALL then resume at 6.
REQ-037 clr versus reset:
- clr at counter=3 (D=5, square) SHALL give counter=0, clk_out=1, and tick=1 on the next cycle.
- Asynchronous reset between edges SHALL zero the outputs immediately and restore div_active=DIV_RESET.
REQ-038 Edge values:
- div_val=0 SHALL load as div_active=1 and behave as D=1 per REQ-029.
- div_val=15 (DIV_WIDTH=4) SHALL give a 15-cycle period with 8 cycles high.
